// File: rtl/score_timer_display.sv
`default_nettype none
// ============================================================================
// Module      : score_timer_display
// Description : Periodically samples score/timer, converts to decimal and
//               drives four active-low 7-segment digits (score or MM:SS).
// Revision    : 1.0 - initial release
// ============================================================================
module score_timer_display #(
    parameter int REFRESH_CYCLES = 5_000_000
) (
    input  logic        clk_50MHz,
    input  logic        rst_n,
    input  logic [7:0]  score,
    input  logic [11:0] timer,
    input  logic        show_score,
    output logic [6:0]  hex3,
    output logic [6:0]  hex2,
    output logic [6:0]  hex1,
    output logic [6:0]  hex0,
    output logic        busy,
    output logic        update_done
);

    localparam int            CW       = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] TICK_VAL = CW'(REFRESH_CYCLES - 1);
    localparam logic [6:0]    BLANK    = 7'h7F;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DIV60 = 3'd1;
    localparam logic [2:0] S_BCD_A = 3'd2;
    localparam logic [2:0] S_BCD_B = 3'd3;
    localparam logic [2:0] S_LATCH = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          mode_q;
    logic [11:0]   rem_q;
    logic [6:0]    min_q;
    logic [7:0]    sh_q;
    logic [11:0]   bcd_q;
    logic [2:0]    bit_q;
    logic [11:0]   res_a_q;
    logic [6:0]    hex3_q, hex2_q, hex1_q, hex0_q;
    logic          upd_q;

    logic          w_tick, w_ge60, w_last;
    logic          w_capture, w_div_step, w_load_min, w_shift_en, w_save_a, w_load_sec, w_latch;
    logic [11:0]   w_adj, w_shift;
    logic [6:0]    w_hex3, w_hex2, w_hex1, w_hex0;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return BLANK;
        endcase
    endfunction

    assign w_tick  = (cnt_q == TICK_VAL);
    assign w_ge60  = (rem_q >= 12'd60);
    assign w_last  = (bit_q == 3'd7);
    assign w_adj   = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    assign w_shift = {w_adj[10:0], sh_q[7]};

    // Refresh counter free-runs regardless of FSM activity
    always_ff @(posedge clk_50MHz) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= w_tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_tick) state_d = show_score ? S_BCD_A : S_DIV60;
            S_DIV60: if (!w_ge60) state_d = S_BCD_A;
            S_BCD_A: if (w_last) state_d = mode_q ? S_LATCH : S_BCD_B;
            S_BCD_B: if (w_last) state_d = S_LATCH;
            S_LATCH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        w_capture  = (state_q == S_IDLE) && w_tick;
        w_div_step = (state_q == S_DIV60) && w_ge60;
        w_load_min = (state_q == S_DIV60) && !w_ge60;
        w_shift_en = (state_q == S_BCD_A) || (state_q == S_BCD_B);
        w_save_a   = (state_q == S_BCD_A) && w_last;
        w_load_sec = (state_q == S_BCD_A) && w_last && !mode_q;
        w_latch    = (state_q == S_LATCH);
    end

    // Display mapping from the finished conversion results
    always_comb begin
        if (mode_q) begin
            w_hex3 = BLANK;
            w_hex2 = (res_a_q[11:8] == 4'd0) ? BLANK : seg7(res_a_q[11:8]);
            w_hex1 = (res_a_q[11:4] == 8'd0) ? BLANK : seg7(res_a_q[7:4]);
            w_hex0 = seg7(res_a_q[3:0]);
        end else begin
            w_hex3 = seg7(res_a_q[7:4]);
            w_hex2 = seg7(res_a_q[3:0]);
            w_hex1 = seg7(bcd_q[7:4]);
            w_hex0 = seg7(bcd_q[3:0]);
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (!rst_n) begin
            mode_q  <= 1'b0;
            rem_q   <= '0;
            min_q   <= '0;
            sh_q    <= '0;
            bcd_q   <= '0;
            bit_q   <= '0;
            res_a_q <= '0;
            hex3_q  <= BLANK;
            hex2_q  <= BLANK;
            hex1_q  <= BLANK;
            hex0_q  <= BLANK;
            upd_q   <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            if (w_capture) begin
                mode_q <= show_score;
                rem_q  <= timer;
                min_q  <= '0;
                sh_q   <= score;
                bcd_q  <= '0;
                bit_q  <= '0;
            end
            if (w_div_step) begin
                rem_q <= rem_q - 12'd60;
                min_q <= min_q + 7'd1;
            end
            if (w_load_min) begin
                sh_q  <= {1'b0, min_q};
                bcd_q <= '0;
                bit_q <= '0;
            end
            if (w_shift_en) begin
                bcd_q <= w_shift;
                sh_q  <= {sh_q[6:0], 1'b0};
                bit_q <= bit_q + 3'd1;
            end
            if (w_save_a) begin
                res_a_q <= w_shift;
            end
            // Seconds conversion reuses the engine once minutes are saved
            if (w_load_sec) begin
                sh_q  <= {2'b00, rem_q[5:0]};
                bcd_q <= '0;
            end
            if (w_latch) begin
                hex3_q <= w_hex3;
                hex2_q <= w_hex2;
                hex1_q <= w_hex1;
                hex0_q <= w_hex0;
                upd_q  <= 1'b1;
            end
        end
    end

    assign hex3        = hex3_q;
    assign hex2        = hex2_q;
    assign hex1        = hex1_q;
    assign hex0        = hex0_q;
    assign update_done = upd_q;

endmodule
`default_nettype wire

// File: tb/tb_score_timer_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_timer_display
// Description : Scoreboard bench for score_timer_display (REFRESH_CYCLES=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_timer_display;

    localparam int REFRESH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  score = '0;
    logic [11:0] timer = '0;
    logic        show_score = 1'b0;
    logic [6:0]  hex3, hex2, hex1, hex0;
    logic        busy, update_done;

    always #5 clk = ~clk;

    score_timer_display #(.REFRESH_CYCLES(REFRESH)) dut (
        .clk_50MHz  (clk),
        .rst_n      (rst_n),
        .score      (score),
        .timer      (timer),
        .show_score (show_score),
        .hex3       (hex3),
        .hex2       (hex2),
        .hex1       (hex1),
        .hex0       (hex0),
        .busy       (busy),
        .update_done(update_done)
    );

    typedef struct {
        logic [6:0] h3, h2, h1, h0;
        int         at;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   total = 0;
    int   bad = 0;
    int   edge_n = 0;
    int   last_l = 0;
    int   spurious = 0;
    bit   sb_active = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic exp_t model(input bit sh, input int sc, input int tm, input int cap);
        exp_t e;
        int h, t, o, m, s;
        if (sh) begin
            h = sc / 100; t = (sc / 10) % 10; o = sc % 10;
            e.h3 = 7'h7F;
            e.h2 = (h == 0) ? 7'h7F : seg(h);
            e.h1 = (h == 0 && t == 0) ? 7'h7F : seg(t);
            e.h0 = seg(o);
            e.at = cap + 9;
        end else begin
            m = tm / 60; s = tm % 60;
            e.h3 = seg(m / 10); e.h2 = seg(m % 10);
            e.h1 = seg(s / 10); e.h0 = seg(s % 10);
            e.at = cap + m + 18;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    // Scoreboard consumer: every update_done pulse pops one expectation
    always @(negedge clk) begin
        if (update_done === 1'b1) begin
            if (sb.size() == 0) begin
                if (sb_active) spurious++;
            end else begin
                e_mon = sb.pop_front();
                check("hex3", int'(hex3), int'(e_mon.h3));
                check("hex2", int'(hex2), int'(e_mon.h2));
                check("hex1", int'(hex1), int'(e_mon.h1));
                check("hex0", int'(hex0), int'(e_mon.h0));
                check("latency_edge", edge_n, e_mon.at);
            end
        end
    end

    task automatic wait_edge(input int target);
        for (int i = 0; i < 200 && edge_n < target; i++) @(negedge clk);
    endtask

    task automatic run_vec(input bit sh, input int sc, input int tm, input bit glitch);
        int   cap;
        exp_t e;
        cap = (last_l / REFRESH + 1) * REFRESH;
        e = model(sh, sc, tm, cap);
        sb.push_back(e);
        show_score = sh;
        score      = 8'(sc);
        timer      = 12'(tm);
        wait_edge(cap);
        check("busy_after_capture", int'(busy), 1);
        if (glitch) begin
            repeat (3) @(negedge clk);
            show_score = ~sh;
            score      = 8'(~sc);
            timer      = 12'(~tm);
        end
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("update_timeout", sb.size(), 0);
            sb.delete();
        end
        last_l = e.at;
    endtask

    initial begin
        int cap;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hex3", int'(hex3), 'h7F);
        check("rst_hex2", int'(hex2), 'h7F);
        check("rst_hex1", int'(hex1), 'h7F);
        check("rst_hex0", int'(hex0), 'h7F);
        check("rst_busy", int'(busy), 0);
        check("rst_update_done", int'(update_done), 0);
        rst_n = 1'b1;
        sb_active = 1'b1;
        wait_edge(REFRESH - 1);
        check("busy_before_first_tick", int'(busy), 0);

        run_vec(1'b1, 100, 0, 1'b0);
        run_vec(1'b1, 7,   0, 1'b0);
        run_vec(1'b1, 255, 0, 1'b0);
        run_vec(1'b1, 0,   0, 1'b0);
        run_vec(1'b1, 99,  0, 1'b0);
        run_vec(1'b0, 0, 1800, 1'b0);
        run_vec(1'b0, 0, 61,   1'b0);
        run_vec(1'b0, 0, 59,   1'b0);
        run_vec(1'b0, 0, 60,   1'b0);
        run_vec(1'b0, 0, 4095, 1'b0);
        run_vec(1'b0, 0, 125,  1'b1);
        run_vec(1'b1, 203, 0,  1'b1);

        // Abort a conversion while dividing
        cap = (last_l / REFRESH + 1) * REFRESH;
        show_score = 1'b0;
        timer      = 12'd1800;
        wait_edge(cap + 5);
        check("busy_in_div60", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_update_done", int'(update_done), 0);
        check("abort_hex3", int'(hex3), 'h7F);
        check("abort_hex2", int'(hex2), 'h7F);
        check("abort_hex1", int'(hex1), 'h7F);
        check("abort_hex0", int'(hex0), 'h7F);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        last_l = 0;
        run_vec(1'b1, 42, 0, 1'b0);

        sb_active = 1'b0;
        check("spurious_updates", spurious, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
